// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DATA_W     : register data width
//   AW         : register address width
//   FIFO_DEPTH : MDU result buffer entries (power of two, >= 2)
//   mdu_res_t  : one buffered MDU result {addr, data}
package rf_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } mdu_res_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO holding MDU results until the register-file port is free.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_valid/ready/data : producer side (MDU)
//   pop_valid/ready/data  : consumer side (write-port mux); pop_data is the head
//   count          : current occupancy
// Both ready and valid are held low while rst is high.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  mdu_res_t                   push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output mdu_res_t                   pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  mdu_res_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign push_ready = !rst && (count < CW'(DEPTH));
  assign pop_valid  = !rst && (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  // Pointers are exactly log2(DEPTH) bits wide, so natural overflow wraps them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has absolute priority, MDU
// results queue in a small FIFO and drain in writeback-free cycles. A busy
// scoreboard of MDU destinations drives the decode hazard signal.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data     : writeback stage write request
//   mdu_valid/mdu_ready/mdu_addr/mdu_data : MDU result handshake
//   md_issue/md_dest          : decode issues an MDU op to md_dest
//   rs_addr/rt_addr/rd_addr   : decode hazard queries
//   hazard                    : a queried non-zero register is MDU-pending
//   rf_we/rf_addr/rf_data     : register-file write port (combinational)
//   defer_cnt                 : saturating count of cycles an MDU result was
//                               blocked by writeback
module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = rf_arb_pkg::DATA_W,
  parameter int unsigned AW         = rf_arb_pkg::AW,
  parameter int unsigned FIFO_DEPTH = rf_arb_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [AW-1:0]     mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              md_issue,
  input  logic [AW-1:0]     md_dest,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  input  logic [AW-1:0]     rd_addr,
  output logic              hazard,
  output logic              rf_we,
  output logic [AW-1:0]     rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [15:0]       defer_cnt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NR = 1 << AW;

  logic            wb_take;
  logic            head_valid;
  logic            pop_go;
  logic            head_wr;
  mdu_res_t        push_res;
  mdu_res_t        head;
  logic [CW-1:0]   count;
  logic [NR-1:0]   busy;
  logic [NR-1:0]   busy_nxt;

  assign push_res.addr = mdu_addr;
  assign push_res.data = mdu_data;

  // A writeback to r0 is a no-op, so it leaves the port free for the FIFO.
  assign wb_take = wb_we && (wb_addr != '0);

  rf_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (mdu_valid),
    .push_ready (mdu_ready),
    .push_data  (push_res),
    .pop_valid  (head_valid),
    .pop_ready  (!wb_take),
    .pop_data   (head),
    .count      (count)
  );

  // head_valid is already low in reset, so pops and head writes stop there too.
  assign pop_go  = head_valid && !wb_take;
  assign head_wr = pop_go && (head.addr != '0);

  always_comb begin
    rf_we   = !rst && (wb_take || head_wr);
    rf_addr = wb_take ? wb_addr : head.addr;
    rf_data = wb_take ? wb_data : head.data;
  end

  // Set after clear so a new issue to the register being written stays busy.
  always_comb begin
    busy_nxt = busy;
    if (head_wr)                      busy_nxt[head.addr] = 1'b0;
    if (md_issue && (md_dest != '0))  busy_nxt[md_dest]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    hazard = !rst && (((rs_addr != '0) && busy[rs_addr]) ||
                      ((rt_addr != '0) && busy[rt_addr]) ||
                      ((rd_addr != '0) && busy[rd_addr]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      defer_cnt <= '0;
    end else if ((count != '0) && wb_take && (defer_cnt != '1)) begin
      defer_cnt <= defer_cnt + 16'd1;
    end
  end

endmodule
